// File: rtl/if_fetch_queue.sv
`default_nettype none
// if_fetch_queue: fetch PC generation with exception/ertn/branch redirect priority,
// one-cycle-latency instruction memory interface and a DEPTH-entry {pc, inst} FIFO to decode.
// Optional build macro IFQ_BYPASS_EN presents a response combinationally when the FIFO is empty.
module if_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h1C000000,
   parameter int          DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     excp_flush,
   input  logic [31:0]              eentry,
   input  logic                     ertn_flush,
   input  logic [31:0]              era,
   input  logic                     br_taken,
   input  logic [31:0]              br_target,
   output logic                     inst_req,
   output logic [31:0]              inst_addr,
   input  logic [31:0]              inst_rdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [63:0]              out_bus,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int              AW      = $clog2(DEPTH);
   localparam logic [AW+1:0]   C_DEPTH = (AW+2)'(DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic          pend_q;
   logic [31:0]   pend_pc_q;
   logic [AW:0]   count_q, count_d;
   logic [AW-1:0] rd_ptr_q, wr_ptr_q;
   logic [63:0]   mem_q [DEPTH];

   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          push, pop;
   logic [63:0]   head;

   always_comb begin
      redirect    = excp_flush | ertn_flush | br_taken;
      redirect_pc = br_target;
      if (excp_flush)      redirect_pc = eentry;
      else if (ertn_flush) redirect_pc = era;
   end

   // Credits come from the registered count only, so a same-cycle pop never frees a slot early.
   assign inst_req  = !redirect && (({1'b0, count_q} + (AW+2)'(pend_q)) < C_DEPTH);
   assign inst_addr = pc_q;
   assign head      = mem_q[rd_ptr_q];
   assign pop       = (count_q != '0) && out_ready && !redirect;
   assign occupancy = count_q;

`ifdef IFQ_BYPASS_EN
   logic bypass_take;
   assign bypass_take = (count_q == '0) && pend_q && !redirect;
   assign out_valid   = (count_q != '0) || bypass_take;
   assign out_bus     = (count_q != '0) ? head :
                        bypass_take      ? {pend_pc_q, inst_rdata} : 64'd0;
   assign push        = pend_q && !redirect && !(bypass_take && out_ready);
`else
   assign out_valid   = (count_q != '0);
   assign out_bus     = out_valid ? head : 64'd0;
   assign push        = pend_q && !redirect;
`endif

   always_comb begin
      pc_d = pc_q;
      if (redirect)      pc_d = redirect_pc;
      else if (inst_req) pc_d = pc_q + 32'd4;
   end

   always_comb begin
      count_d = count_q;
      if (redirect)           count_d = '0;
      else if (push && !pop)  count_d = count_q + (AW+1)'(1);
      else if (pop && !push)  count_d = count_q - (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q      <= RESET_PC;
         pend_q    <= 1'b0;
         pend_pc_q <= 32'd0;
         count_q   <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
      end else begin
         pc_q    <= pc_d;
         pend_q  <= inst_req;
         count_q <= count_d;
         if (inst_req) pend_pc_q <= pc_q;
         if (redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   // Storage needs no reset: out_bus is gated by count, which is reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {pend_pc_q, inst_rdata};
   end

endmodule
`default_nettype wire
